ssd_scan_ctrl: RTL and testbench

// - Time-multiplexes one shared 7-segment segment bus between NUM_DIG digit requesters.
// - Internal prescaler sets the scan rate; rotates digit select; decodes 4-bit hex per digit.
// - Inserts an all-off guard interval before each digit to suppress ghosting.
// - Sits between the counter/stopwatch datapath (digits in) and the board SSD pins.

---
 rtl/ssd_scan_if.sv | 22 ++
 rtl/ssd_scan_ctrl.sv | 155 +++++++++++++++
 tb/tb_ssd_scan_ctrl.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/ssd_scan_if.sv
// Bundle between the digit datapath (master) and the SSD scan controller (slave).
interface ssd_scan_if #(
  parameter int NUM_DIG = 4
);
  logic                   en;
  logic [4*NUM_DIG-1:0]   digits;
  logic [NUM_DIG-1:0]     dp;
  logic [NUM_DIG-1:0]     blank_mask;
  logic [NUM_DIG-1:0]     ssd_ctl;
  logic [7:0]             ssd_out;
  logic                   scan_tick;

  modport master (
    output en, digits, dp, blank_mask,
    input  ssd_ctl, ssd_out, scan_tick
  );

  modport slave (
    input  en, digits, dp, blank_mask,
    output ssd_ctl, ssd_out, scan_tick
  );
endinterface

// File: rtl/ssd_scan_ctrl.sv
// Multiplexed 7-segment scan controller: prescaled digit rotation, hex decode,
// all-off guard interval ahead of each digit slot, per-digit blanking.
// Optional feature macro: SSD_SCAN_LZB_EN enables leading-zero blanking.
module ssd_scan_ctrl #(
  parameter int SCAN_DIV  = 10000,
  parameter int GUARD_CYC = 4,
  parameter int NUM_DIG   = 4,
  parameter int CNT_W     = 27
) (
  input  logic        clk,
  input  logic        rst,
  ssd_scan_if.slave   bus
);

  localparam int IDX_W = $clog2(NUM_DIG);
  localparam int GC_W  = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;

  typedef enum logic [1:0] {IDLE, GUARD, SHOW} state_t;

  state_t             state, state_n;
  logic [IDX_W-1:0]   idx, idx_n;
  logic [CNT_W-1:0]   presc, presc_n;
  logic [GC_W-1:0]    gcnt, gcnt_n;
  logic [3:0]         dig_q, dig_n;
  logic               dp_q, dp_n;
  logic               blk_q, blk_n;
  logic [NUM_DIG-1:0] ctl_q, ctl_n;
  logic [7:0]         out_q, out_n;
  logic               tick_q, tick_n;
  logic [NUM_DIG-1:0] auto_blank;
  logic               slot_end;
  logic               guard_done;
  logic               load;
  logic [7:0]         seg;

  // Hex to active-low segments {a..g,dp}, dp off.
  function automatic logic [7:0] seg7(input logic [3:0] h);
    case (h)
      4'h0: seg7 = 8'h03;  4'h1: seg7 = 8'h9F;  4'h2: seg7 = 8'h25;  4'h3: seg7 = 8'h0D;
      4'h4: seg7 = 8'h99;  4'h5: seg7 = 8'h49;  4'h6: seg7 = 8'h41;  4'h7: seg7 = 8'h1F;
      4'h8: seg7 = 8'h01;  4'h9: seg7 = 8'h09;  4'hA: seg7 = 8'h11;  4'hB: seg7 = 8'hC1;
      4'hC: seg7 = 8'h63;  4'hD: seg7 = 8'h85;  4'hE: seg7 = 8'h61;  default: seg7 = 8'h71;
    endcase
  endfunction

  assign slot_end   = (presc == CNT_W'(SCAN_DIV - 1));
  assign guard_done = (GUARD_CYC <= 1) || (gcnt == GC_W'(GUARD_CYC - 1));

  // Automatic blanking flags per digit (leading zeros when enabled).
`ifdef SSD_SCAN_LZB_EN
  logic zero_above;
  always_comb begin
    auto_blank = '0;
    zero_above = 1'b1;
    for (int unsigned k = NUM_DIG - 1; k >= 1; k--) begin
      zero_above    = zero_above & (bus.digits[4*k +: 4] == 4'h0);
      auto_blank[k] = zero_above;
    end
  end
`else
  // Only the external mask blanks digits.
  always_comb begin
    auto_blank = '0;
  end
`endif

  // Next-state, slot timing and next registered outputs.
  // Outputs are computed from the next state so that the registered pins line
  // up with the state they describe (scan_tick high during the last slot cycle).
  always_comb begin
    state_n = state;
    idx_n   = idx;
    presc_n = presc;
    gcnt_n  = gcnt;
    if (!bus.en) begin
      state_n = IDLE;
      idx_n   = '0;
      presc_n = '0;
      gcnt_n  = '0;
    end else begin
      case (state)
        IDLE: begin
          idx_n   = '0;
          presc_n = '0;
          gcnt_n  = '0;
          state_n = (GUARD_CYC == 0) ? SHOW : GUARD;
        end
        default: begin
          if (slot_end) begin
            presc_n = '0;
            gcnt_n  = '0;
            idx_n   = (idx == IDX_W'(NUM_DIG - 1)) ? '0 : idx + 1'b1;
            state_n = (GUARD_CYC == 0) ? SHOW : GUARD;
          end else begin
            presc_n = presc + 1'b1;
            if (state == GUARD) begin
              if (guard_done) begin
                gcnt_n  = '0;
                state_n = SHOW;
              end else begin
                gcnt_n  = gcnt + 1'b1;
              end
            end
          end
        end
      endcase
    end

    load  = (state_n == SHOW) && ((state != SHOW) || slot_end);
    dig_n = load ? bus.digits[{idx_n, 2'b00} +: 4] : dig_q;
    dp_n  = load ? bus.dp[idx_n] : dp_q;
    blk_n = load ? (bus.blank_mask[idx_n] | auto_blank[idx_n]) : blk_q;

    seg   = seg7(dig_n);
    ctl_n = '1;
    out_n = 8'hFF;
    if ((state_n == SHOW) && !blk_n) begin
      ctl_n = ~(NUM_DIG'(1) << idx_n);
      out_n = {seg[7:1], ~dp_n};
    end
    tick_n = (state_n != IDLE) && (presc_n == CNT_W'(SCAN_DIV - 1));
  end

  // State, counters, sampled digit and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      presc  <= '0;
      gcnt   <= '0;
      dig_q  <= '0;
      dp_q   <= 1'b0;
      blk_q  <= 1'b0;
      ctl_q  <= '1;
      out_q  <= 8'hFF;
      tick_q <= 1'b0;
    end else begin
      state  <= state_n;
      idx    <= idx_n;
      presc  <= presc_n;
      gcnt   <= gcnt_n;
      dig_q  <= dig_n;
      dp_q   <= dp_n;
      blk_q  <= blk_n;
      ctl_q  <= ctl_n;
      out_q  <= out_n;
      tick_q <= tick_n;
    end
  end

  assign bus.ssd_ctl   = ctl_q;
  assign bus.ssd_out   = out_q;
  assign bus.scan_tick = tick_q;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Bench for ssd_scan_ctrl: slot/frame model checked every cycle plus literal pins.
module tb_ssd_scan_ctrl;
  localparam int SD = 8;
  localparam int GC = 2;
  localparam int ND = 4;
  localparam logic [7:0] SEG [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                                      8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  ssd_scan_if #(.NUM_DIG(ND)) bus ();

  ssd_scan_ctrl #(.SCAN_DIV(SD), .GUARD_CYC(GC), .NUM_DIG(ND), .CNT_W(27)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Model: time since scanning began, plus what was latched at each slot's sample point.
  bit       m_run = 1'b0;
  int       m_t   = 0;
  logic [3:0] s_dig = '0;
  bit       s_dp  = 1'b0;
  bit       s_blk = 1'b0;

  function automatic bit lz_blank(input logic [15:0] d, input int k);
    logic [15:0] v;
    if (k == 0) return 1'b0;
    for (int j = k; j < ND; j++) begin
      v = d >> (4 * j);
      if (v[3:0] != 4'h0) return 1'b0;
    end
    return 1'b1;
  endfunction

  always @(posedge clk or posedge rst) begin
    bit          run_n;
    int          t_n;
    int          sl;
    logic [15:0] tmp;
    if (rst) begin
      m_run <= 1'b0;
      m_t   <= 0;
    end else if (!bus.en) begin
      m_run <= 1'b0;
      m_t   <= 0;
    end else begin
      run_n = 1'b1;
      t_n   = m_run ? m_t + 1 : 0;
      m_run <= run_n;
      m_t   <= t_n;
      if (t_n % SD == GC) begin
        sl  = (t_n / SD) % ND;
        tmp = bus.digits >> (4 * sl);
        s_dig <= tmp[3:0];
        s_dp  <= bus.dp[sl];
`ifdef SSD_SCAN_LZB_EN
        s_blk <= bus.blank_mask[sl] | lz_blank(bus.digits, sl);
`else
        s_blk <= bus.blank_mask[sl];
`endif
      end
    end
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    logic [3:0] e_ctl;
    logic [7:0] e_out;
    logic [7:0] sv;
    logic       e_tick;
    int         ph, sl;
    e_ctl  = 4'hF;
    e_out  = 8'hFF;
    e_tick = 1'b0;
    if (m_run) begin
      ph     = m_t % SD;
      sl     = (m_t / SD) % ND;
      e_tick = (ph == SD - 1);
      if (ph >= GC && !s_blk) begin
        sv    = SEG[s_dig];
        e_ctl = ~(4'b0001 << sl);
        e_out = {sv[7:1], ~s_dp};
      end
    end
    chk("model_ctl",  {4'h0, bus.ssd_ctl}, {4'h0, e_ctl});
    chk("model_out",  bus.ssd_out, e_out);
    chk("model_tick", {7'h0, bus.scan_tick}, {7'h0, e_tick});
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pin(input string nm, input logic [3:0] ctl, input logic [7:0] out);
    @(negedge clk);
    chk({nm, "_ctl"}, {4'h0, bus.ssd_ctl}, {4'h0, ctl});
    chk({nm, "_out"}, bus.ssd_out, out);
  endtask

  task automatic pin_tick(input string nm, input logic t);
    @(negedge clk);
    chk(nm, {7'h0, bus.scan_tick}, {7'h0, t});
  endtask

  initial begin
    bus.en = 1'b0; bus.digits = 16'h1234; bus.dp = '0; bus.blank_mask = '0;
    step(2);
    rst = 1'b0;
    step(20);
    pin("idle_dark", 4'hF, 8'hFF);
    pin_tick("idle_tick", 1'b0);

    // Basic rotation through 1234
    bus.en = 1'b1;
    step(1);  pin("guard0", 4'hF, 8'hFF);
    step(2);  pin("show0", 4'hE, 8'h99);
    step(5);  pin_tick("tick0", 1'b1);
    step(3);  pin("show1", 4'hD, 8'h0D);
    step(16); pin("show3", 4'h7, 8'h9F);
    step(8);  pin("wrap0", 4'hE, 8'h99);

    // Decimal point and mask
    bus.dp = 4'b0010; bus.digits = 16'h0008; bus.blank_mask = 4'b0100;
    step(9);
`ifdef SSD_SCAN_LZB_EN
    pin("dp1", 4'hF, 8'hFF);
`else
    pin("dp1", 4'hD, 8'h02);
`endif
    step(8);  pin("mask2", 4'hF, 8'hFF);

    // Mid-slot change is held until the next visit
    bus.dp = '0; bus.digits = 16'h1234; bus.blank_mask = '0;
    step(16); pin("hold_a", 4'hE, 8'h99);
    bus.digits = 16'h123F;
    step(1);  pin("hold_b", 4'hE, 8'h99);
    step(30); pin("next_visit", 4'hE, 8'h71);

    // en drop entering the last slot cycle
    step(4);  bus.en = 1'b0;
    step(1);  pin("en_drop_a", 4'hF, 8'hFF);
    pin_tick("en_drop_a_tick", 1'b0);
    step(3);  bus.en = 1'b1;
    step(3);  pin("restart_a", 4'hE, 8'h71);
    // en drop right after the tick cycle
    step(5);  pin_tick("tick_before_drop", 1'b1);
    bus.en = 1'b0;
    step(1);  pin_tick("en_drop_b_tick", 1'b0);
    pin("en_drop_b", 4'hF, 8'hFF);
    step(2);  bus.en = 1'b1;
    step(3);  pin("restart_b", 4'hE, 8'h71);

    // Reset mid-slot
    step(2);  rst = 1'b1;
    pin("rst_dark", 4'hF, 8'hFF);
    step(2);  rst = 1'b0;
    step(3);  pin("rst_restart", 4'hE, 8'h71);

    // Leading zeros
    bus.en = 1'b0; bus.digits = 16'h0050;
    step(2);  bus.en = 1'b1;
    step(3);  pin("lz_d0", 4'hE, 8'h03);
    step(8);  pin("lz_d1", 4'hD, 8'h49);
    step(8);
`ifdef SSD_SCAN_LZB_EN
    pin("lz_d2", 4'hF, 8'hFF);
    step(8);  pin("lz_d3", 4'hF, 8'hFF);
`else
    pin("lz_d2", 4'hB, 8'h03);
    step(8);  pin("lz_d3", 4'h7, 8'h03);
`endif
    bus.digits = 16'h0000;
    step(8);  pin("zero_d0", 4'hE, 8'h03);
    step(8);
`ifdef SSD_SCAN_LZB_EN
    pin("zero_d1", 4'hF, 8'hFF);
`else
    pin("zero_d1", 4'hD, 8'h03);
`endif
    step(4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
